// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: sequential 32-bit little-endian fetch from a
// byte-addressed, program-loadable memory, with branch redirect and a sticky
// fault state for misaligned redirect targets.
module instruction_fetch_unit #(
   parameter int ADDR_W = 8,
   parameter int SIZE   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] target,
   input  logic              ld_en,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [7:0]        ld_data,
   output logic [SIZE-1:0]   Instruction,
   output logic [ADDR_W-1:0] pc_out,
   output logic              valid,
   output logic              fault
);

   localparam int DEPTH = 2**ADDR_W;
   localparam int LANES = SIZE / 8;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FAULT = 1'b1
   } state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] pc_reg, pc_next;
   logic [ADDR_W-1:0] pc_out_reg, pc_out_next;
   logic [SIZE-1:0]   instr_reg, instr_next;
   logic              valid_reg, valid_next;
   logic              fault_reg, fault_next;
   logic [SIZE-1:0]   fetch_word;

   // Each entry stores (byte XOR low address byte). Storage powers up as
   // zero, so an unwritten location reads back as its own address mod 256,
   // which gives the required preloaded image without an init block.
   logic [7:0] mem_reg [DEPTH];

   // Low eight bits of a byte address (zero-extended for narrow memories).
   function automatic logic [7:0] addr_tag(input logic [ADDR_W-1:0] a);
      return 8'(a);
   endfunction

   // Program-load write port; contents are deliberately untouched by reset.
   always_ff @(posedge clk) begin
      if (ld_en) begin
         mem_reg[ld_addr] <= ld_data ^ addr_tag(ld_addr);
      end
   end

   // Little-endian word assembly; byte addresses wrap modulo the memory size.
   // Reads see the pre-edge contents, so a same-edge load is not forwarded.
   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         logic [ADDR_W-1:0] lane_addr;
         assign lane_addr = pc_reg + ADDR_W'(gi);
         assign fetch_word[8*gi +: 8] = mem_reg[lane_addr] ^ addr_tag(lane_addr);
      end
   endgenerate

   // State and datapath registers; reset clears everything except memory.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg  <= ST_RUN;
         pc_reg     <= '0;
         pc_out_reg <= '0;
         instr_reg  <= '0;
         valid_reg  <= 1'b0;
         fault_reg  <= 1'b0;
      end else begin
         state_reg  <= state_next;
         pc_reg     <= pc_next;
         pc_out_reg <= pc_out_next;
         instr_reg  <= instr_next;
         valid_reg  <= valid_next;
         fault_reg  <= fault_next;
      end
   end

   // Next-state logic: redirect beats stall beats sequential fetch.
   always_comb begin
      state_next  = state_reg;
      pc_next     = pc_reg;
      pc_out_next = pc_out_reg;
      instr_next  = instr_reg;
      valid_next  = valid_reg;
      fault_next  = fault_reg;
      case (state_reg)
         ST_RUN: begin
            if (redirect) begin
               // Either path leaves a one-cycle bubble on valid.
               valid_next = 1'b0;
               if (target[1:0] == 2'b00) begin
                  pc_next = target;
               end else begin
                  state_next = ST_FAULT;
                  fault_next = 1'b1;
               end
            end else if (!stall) begin
               instr_next  = fetch_word;
               pc_out_next = pc_reg;
               valid_next  = 1'b1;
               pc_next     = pc_reg + ADDR_W'(4);
            end
         end
         ST_FAULT: begin
            // Locked until reset; only valid is forced low.
            valid_next = 1'b0;
         end
         default: begin
            state_next = ST_RUN;
         end
      endcase
   end

   assign Instruction = instr_reg;
   assign pc_out      = pc_out_reg;
   assign valid       = valid_reg;
   assign fault       = fault_reg;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit: directed scenarios plus randomized
// traffic, checked by a scoreboard fed from a byte-array reference model.
module tb_instruction_fetch_unit;

   localparam int ADDR_W = 8;
   localparam int DEPTH  = 2**ADDR_W;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [7:0]  target = '0;
   logic        ld_en = 1'b0;
   logic [7:0]  ld_addr = '0;
   logic [7:0]  ld_data = '0;
   logic [31:0] Instruction;
   logic [7:0]  pc_out;
   logic        valid;
   logic        fault;

   instruction_fetch_unit #(.ADDR_W(ADDR_W), .SIZE(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .redirect    (redirect),
      .target      (target),
      .ld_en       (ld_en),
      .ld_addr     (ld_addr),
      .ld_data     (ld_data),
      .Instruction (Instruction),
      .pc_out      (pc_out),
      .valid       (valid),
      .fault       (fault)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] instr;
      logic [7:0]  pc;
      logic        valid;
      logic        fault;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   txn = 0;

   // Reference model state: plain byte array and integer program counter.
   byte unsigned m_mem [DEPTH];
   int           m_pc = 0;
   logic [31:0]  m_instr = '0;
   int           m_pcout = 0;
   bit           m_valid = 1'b0;
   bit           m_fault = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model_word(input int pc);
      logic [31:0] w;
      w = '0;
      for (int k = 0; k < 4; k++) begin
         w = w | (32'(m_mem[(pc + k) % DEPTH]) << (8 * k));
      end
      return w;
   endfunction

   task automatic model_step(input bit st, input bit rd, input int tg,
                             input bit le, input int la, input int ldv);
      if (m_fault) begin
         m_valid = 1'b0;
      end else if (rd) begin
         m_valid = 1'b0;
         if (tg % 4 == 0) m_pc = tg % DEPTH;
         else             m_fault = 1'b1;
      end else if (!st) begin
         m_instr = model_word(m_pc);
         m_pcout = m_pc;
         m_valid = 1'b1;
         m_pc    = (m_pc + 4) % DEPTH;
      end
      // Load lands after the fetch has read memory.
      if (le) m_mem[la % DEPTH] = 8'(ldv);
   endtask

   task automatic drive_step(input bit st, input bit rd, input int tg,
                             input bit le, input int la, input int ldv);
      @(negedge clk);
      stall    = st;
      redirect = rd;
      target   = 8'(tg);
      ld_en    = le;
      ld_addr  = 8'(la);
      ld_data  = 8'(ldv);
      model_step(st, rd, tg, le, la, ldv);
   endtask

   // One edge whose expected result comes from the reference model.
   task automatic cycle(input bit st, input bit rd, input int tg,
                        input bit le, input int la, input int ldv);
      exp_t e;
      drive_step(st, rd, tg, le, la, ldv);
      e = '{m_instr, 8'(m_pcout), m_valid, m_fault};
      sb_q.push_back(e);
   endtask

   // One edge whose expected result is a hand-written constant.
   task automatic dcyc(input bit st, input bit rd, input int tg,
                       input bit le, input int la, input int ldv,
                       input logic [31:0] ki, input int kp, input bit kv, input bit kf);
      exp_t e;
      drive_step(st, rd, tg, le, la, ldv);
      e = '{ki, 8'(kp), kv, kf};
      sb_q.push_back(e);
   endtask

   // Assert reset between edges, confirm the outputs clear at once, hold it
   // across one edge and release it between edges.
   task automatic apply_reset();
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      chk("rst_async_instr", Instruction, 32'h0);
      chk("rst_async_pc_out", 32'(pc_out), 32'h0);
      chk("rst_async_valid", 32'(valid), 32'h0);
      chk("rst_async_fault", 32'(fault), 32'h0);
      stall = 1'b0;
      redirect = 1'b0;
      ld_en = 1'b0;
      @(posedge clk);
      #3;
      reset   = 1'b1;
      m_pc    = 0;
      m_instr = '0;
      m_pcout = 0;
      m_valid = 1'b0;
      m_fault = 1'b0;
   endtask

   // Monitor: one scoreboard entry per clock edge, compared after the edge.
   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            txn++;
            chk($sformatf("txn%0d instr", txn), Instruction, e.instr);
            chk($sformatf("txn%0d pc_out", txn), 32'(pc_out), 32'(e.pc));
            chk($sformatf("txn%0d valid", txn), 32'(valid), 32'(e.valid));
            chk($sformatf("txn%0d fault", txn), 32'(fault), 32'(e.fault));
            $display("txn %0d: pc_out=%h instr=%h valid=%0d fault=%0d",
                     txn, pc_out, Instruction, valid, fault);
         end
      end
   end

   initial begin : stimulus
      int waitc;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'(i % 256);

      apply_reset();

      // Sequential fetch from reset.
      dcyc(0, 0, 0, 0, 0, 0, 32'h03020100, 8'h00, 1, 0);
      dcyc(0, 0, 0, 0, 0, 0, 32'h07060504, 8'h04, 1, 0);
      dcyc(0, 0, 0, 0, 0, 0, 32'h0B0A0908, 8'h08, 1, 0);

      // Redirect near the top of memory and wrap around.
      dcyc(0, 1, 8'hFC, 0, 0, 0, 32'h0B0A0908, 8'h08, 0, 0);
      dcyc(0, 0, 0, 0, 0, 0, 32'hFFFEFDFC, 8'hFC, 1, 0);
      dcyc(0, 0, 0, 0, 0, 0, 32'h03020100, 8'h00, 1, 0);

      // Stall for three cycles with a redirect on the second one.
      dcyc(0, 0, 0, 0, 0, 0, 32'h07060504, 8'h04, 1, 0);
      dcyc(1, 0, 0, 0, 0, 0, 32'h07060504, 8'h04, 1, 0);
      dcyc(1, 1, 8'h10, 0, 0, 0, 32'h07060504, 8'h04, 0, 0);
      dcyc(1, 0, 0, 0, 0, 0, 32'h07060504, 8'h04, 0, 0);
      dcyc(0, 0, 0, 0, 0, 0, 32'h13121110, 8'h10, 1, 0);

      // Misaligned redirect locks into fault until reset.
      dcyc(0, 1, 8'h02, 0, 0, 0, 32'h13121110, 8'h10, 0, 1);
      dcyc(0, 1, 8'h08, 0, 0, 0, 32'h13121110, 8'h10, 0, 1);
      dcyc(0, 0, 0, 0, 0, 0, 32'h13121110, 8'h10, 0, 1);
      apply_reset();
      dcyc(0, 0, 0, 0, 0, 0, 32'h03020100, 8'h00, 1, 0);

      // Load into the word being fetched on the same edge.
      dcyc(0, 0, 0, 1, 8'h05, 8'hAA, 32'h07060504, 8'h04, 1, 0);
      dcyc(0, 1, 8'h04, 0, 0, 0, 32'h07060504, 8'h04, 0, 0);
      dcyc(0, 0, 0, 0, 0, 0, 32'h0706AA04, 8'h04, 1, 0);

      // Reset mid-run, mid-stall and mid-bubble; memory must survive.
      cycle(0, 0, 0, 0, 0, 0);
      apply_reset();
      dcyc(0, 0, 0, 0, 0, 0, 32'h03020100, 8'h00, 1, 0);
      cycle(1, 0, 0, 0, 0, 0);
      apply_reset();
      cycle(0, 1, 8'h20, 0, 0, 0);
      apply_reset();
      dcyc(0, 0, 0, 0, 0, 0, 32'h03020100, 8'h00, 1, 0);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 1500; i++) begin
         bit st, rd, le;
         int tg, la, ldv;
         st  = ($urandom_range(0, 3) == 0);
         rd  = ($urandom_range(0, 9) == 0);
         tg  = int'($urandom_range(0, 63)) * 4;
         if ($urandom_range(0, 19) == 0) tg = tg | int'($urandom_range(1, 3));
         le  = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 1) == 0) la = (m_pc + int'($urandom_range(0, 3))) % DEPTH;
         else                           la = int'($urandom_range(0, DEPTH - 1));
         ldv = int'($urandom_range(0, 255));
         cycle(st, rd, tg, le, la, ldv);
         if (m_fault && $urandom_range(0, 7) == 0) apply_reset();
         else if ($urandom_range(0, 299) == 0)    apply_reset();
      end

      // Let the monitor drain, bounded.
      @(negedge clk);
      stall = 1'b0;
      redirect = 1'b0;
      ld_en = 1'b0;
      waitc = 0;
      while (sb_q.size() > 0 && waitc < 20) begin
         @(posedge clk);
         waitc++;
      end
      #2;
      checks++;
      if (sb_q.size() > 0) begin
         errors++;
         $display("FAIL drain: pending=%0d expected 0", sb_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 8: byte-address width; memory depth = 2**ADDR_W bytes.
REQ-002 Parameter SIZE, default 32: instruction width; fixed at 32, four bytes per instruction.
REQ-003 clk  input  1  rising-edge clock, the only clock.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  when 1, hold PC and all outputs.
REQ-006 redirect  input  1  branch/jump request; PC loads target.
REQ-007 target  input  ADDR_W  redirect byte address.
REQ-008 ld_en  input  1  program-load byte write enable.
REQ-009 ld_addr  input  ADDR_W  program-load byte address.
REQ-010 ld_data  input  8  program-load byte.
REQ-011 Instruction  output  SIZE  registered fetched word.
REQ-012 pc_out  output  ADDR_W  byte address of Instruction.
REQ-013 valid  output  1  Instruction/pc_out hold a real fetch this cycle.
REQ-014 fault  output  1  sticky misaligned-redirect flag.

Function
REQ-015 Memory is a byte array of 2**ADDR_W entries; initial content mem[i] = i mod 256.
REQ-016 Word assembly is little-endian: Instruction[8k+7:8k] = mem[(pc+k) mod 2**ADDR_W], k = 0..3; byte addresses wrap.
REQ-017 Internal PC register: ADDR_W bits; increment is +4 mod 2**ADDR_W, with no carry-out kept.
REQ-018 Two states: RUN and FAULT; reset enters RUN.
REQ-019 RUN with stall=0 and redirect=0, per edge: Instruction <= word(PC); pc_out <= PC; valid <= 1; PC <= PC+4.
REQ-020 RUN with redirect=1 and target[1:0]=00, per edge: PC <= target; valid <= 0 (one-cycle bubble); Instruction and pc_out hold.
REQ-021 RUN with redirect=1 and target[1:0]!=00, per edge: enter FAULT; fault <= 1; valid <= 0; PC holds.
REQ-022 Priority order: redirect > stall > sequential fetch; redirect during stall is taken.
REQ-023 RUN with stall=1 and redirect=0: PC, Instruction, pc_out and valid all hold.
REQ-024 FAULT: valid = 0; PC, Instruction and pc_out hold; stall and redirect are ignored; exit only through reset.
REQ-025 ld_en=1 writes ld_data to mem[ld_addr] at the edge, in any state and regardless of stall.
REQ-026 A fetch at the same edge as a load to one of its four bytes returns the pre-write byte (read-before-write).
REQ-027 Memory content is not cleared by reset.
REQ-028 Fetch latency: word(PC) appears on Instruction one edge after PC is presented; throughput is one word per unstalled cycle.

Reset
REQ-029 reset=0 asynchronously forces: PC=0, Instruction=0, pc_out=0, valid=0, fault=0, state=RUN.
REQ-030 Reset asserted mid-operation (stall, redirect bubble, or FAULT) takes effect immediately, without waiting for an edge.
REQ-031 First edge after reset=1: Instruction=0x03020100, pc_out=0, valid=1.

Verification
REQ-032 Release reset, stall=0, 3 edges -> Instruction 0x03020100, 0x07060504, 0x0B0A0908; pc_out 0,4,8; valid=1 throughout.
REQ-033 ADDR_W=8, redirect to 0xFC, then run -> bubble (valid=0), then 0xFFFEFDFC at pc_out=0xFC, then 0x03020100 at pc_out=0x00 (wrap).
REQ-034 Steady run at pc_out=4; stall=1 for 3 cycles; redirect=1 to 0x10 on the 2nd stalled cycle -> outputs held, then bubble, then 0x13121110 at pc_out=0x10.
REQ-035 redirect to 0x02 -> fault=1, valid=0; later redirect to 0x08 ignored; reset -> fault=0, next fetch 0x03020100.
REQ-036 ld_en with ld_addr=0x05, ld_data=0xAA on the edge fetching PC=4 -> 0x07060504 on that fetch; redirect to 4 -> 0x0706AA04.
REQ-037 Assert reset mid-cycle between edges during a run -> outputs go to 0 and valid to 0 before the next edge.
